// File: rtl/ysyx_22040759_decode_stage.sv
// Decode stage: registers one decoded RV64I/RV32I instruction behind a valid/ready handshake.
// Define YSYX_22040759_RVM_EN to also decode the M extension.
module ysyx_22040759_decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_alu_sel,
  output logic [1:0]      out_alu_a_sel,
  output logic [1:0]      out_alu_b_sel,
  output logic [1:0]      out_pc_sel,
  output logic [1:0]      out_wreg_sel,
  output logic            out_reg_wen,
  output logic            out_mem_wen,
  output logic            out_mem_ren,
  output logic [2:0]      out_func3,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("XLEN must be 32 or 64");
  end

`ifdef YSYX_22040759_RVM_EN
  localparam logic RVM_EN = 1'b1;
`else
  localparam logic RVM_EN = 1'b0;
`endif

  localparam logic [4:0] ALU_ADD    = 5'd0,  ALU_SUB    = 5'd1,  ALU_SLL   = 5'd2,
                         ALU_SLT    = 5'd3,  ALU_SLTU   = 5'd4,  ALU_XOR   = 5'd5,
                         ALU_SRL    = 5'd6,  ALU_SRA    = 5'd7,  ALU_OR    = 5'd8,
                         ALU_AND    = 5'd9,  ALU_ADDW   = 5'd10, ALU_SUBW  = 5'd11,
                         ALU_SLLW   = 5'd12, ALU_SRLW   = 5'd13, ALU_SRAW  = 5'd14,
                         ALU_MUL    = 5'd16, ALU_MULH   = 5'd17, ALU_MULHSU = 5'd18,
                         ALU_MULHU  = 5'd19, ALU_DIV    = 5'd20, ALU_DIVU  = 5'd21,
                         ALU_REM    = 5'd22, ALU_REMU   = 5'd23, ALU_MULW  = 5'd24,
                         ALU_DIVW   = 5'd25, ALU_DIVUW  = 5'd26, ALU_REMW  = 5'd27,
                         ALU_REMUW  = 5'd28;

  // a: rs1/pc/zero; b: rs2/imm/4; pc: +4/jal/jalr/branch unit; wreg: alu/mem/pc+4
  localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
  localparam logic [1:0] PC_SEQ = 2'd0, PC_JAL = 2'd1, PC_JALR = 2'd2, PC_BRANCH = 2'd3;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OPIMM32 = 7'b0011011,
                         OPC_OP = 7'b0110011, OPC_OP32 = 7'b0111011, OPC_FENCE = 7'b0001111,
                         OPC_SYSTEM = 7'b1110011;

  localparam logic XLEN64 = (XLEN == 64);

  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    base_alu = alt ? ALU_SUB : ALU_ADD;
      3'd1:    base_alu = ALU_SLL;
      3'd2:    base_alu = ALU_SLT;
      3'd3:    base_alu = ALU_SLTU;
      3'd4:    base_alu = ALU_XOR;
      3'd5:    base_alu = alt ? ALU_SRA : ALU_SRL;
      3'd6:    base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  function automatic logic [4:0] mul_alu(input logic [2:0] f3);
    case (f3)
      3'd0:    mul_alu = ALU_MUL;
      3'd1:    mul_alu = ALU_MULH;
      3'd2:    mul_alu = ALU_MULHSU;
      3'd3:    mul_alu = ALU_MULHU;
      3'd4:    mul_alu = ALU_DIV;
      3'd5:    mul_alu = ALU_DIVU;
      3'd6:    mul_alu = ALU_REM;
      default: mul_alu = ALU_REMU;
    endcase
  endfunction

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, d_imm32;
  logic [4:0]  d_alu;
  logic [1:0]  d_a_sel, d_b_sel, d_pc_sel, d_wreg_sel;
  logic        d_reg_wen, d_mem_wen, d_mem_ren, d_ill;
  logic        shamt_hi_zero, sra_hi_ok, accept;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // shamt[5] is only a valid shift-amount bit on 64-bit datapaths
  assign shamt_hi_zero = XLEN64 ? (in_inst[31:26] == 6'b0) : (in_inst[31:25] == 7'b0);
  assign sra_hi_ok     = (in_inst[31:26] == 6'b010000) && (XLEN64 || !in_inst[25]);

  always_comb begin
    d_imm32    = 32'b0;
    d_alu      = ALU_ADD;
    d_a_sel    = A_RS1;
    d_b_sel    = B_RS2;
    d_pc_sel   = PC_SEQ;
    d_wreg_sel = WB_ALU;
    d_reg_wen  = 1'b0;
    d_mem_wen  = 1'b0;
    d_mem_ren  = 1'b0;
    d_ill      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d_imm32 = imm_u; d_a_sel = A_ZERO; d_b_sel = B_IMM; d_reg_wen = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm32 = imm_u; d_a_sel = A_PC; d_b_sel = B_IMM; d_reg_wen = 1'b1;
      end
      OPC_JAL: begin
        d_imm32 = imm_j; d_a_sel = A_PC; d_b_sel = B_FOUR;
        d_pc_sel = PC_JAL; d_wreg_sel = WB_PC4; d_reg_wen = 1'b1;
      end
      OPC_JALR: begin
        d_imm32 = imm_i; d_a_sel = A_PC; d_b_sel = B_FOUR;
        d_pc_sel = PC_JALR; d_wreg_sel = WB_PC4; d_reg_wen = 1'b1;
        d_ill = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        d_imm32 = imm_b; d_alu = ALU_SUB; d_pc_sel = PC_BRANCH;
        d_ill = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        d_imm32 = imm_i; d_b_sel = B_IMM; d_mem_ren = 1'b1;
        d_reg_wen = 1'b1; d_wreg_sel = WB_MEM;
        d_ill = (funct3 == 3'd7) || (!XLEN64 && (funct3 == 3'd3 || funct3 == 3'd6));
      end
      OPC_STORE: begin
        d_imm32 = imm_s; d_b_sel = B_IMM; d_mem_wen = 1'b1;
        d_ill = funct3[2] || (!XLEN64 && funct3 == 3'd3);
      end
      OPC_OPIMM: begin
        d_imm32 = imm_i; d_b_sel = B_IMM; d_reg_wen = 1'b1;
        case (funct3)
          3'd1:    if (shamt_hi_zero) d_alu = ALU_SLL; else d_ill = 1'b1;
          3'd5: begin
            if (shamt_hi_zero)  d_alu = ALU_SRL;
            else if (sra_hi_ok) d_alu = ALU_SRA;
            else                d_ill = 1'b1;
          end
          default: d_alu = base_alu(funct3, 1'b0);
        endcase
      end
      OPC_OPIMM32: begin
        d_imm32 = imm_i; d_b_sel = B_IMM; d_reg_wen = 1'b1;
        if (!XLEN64) d_ill = 1'b1;
        else if (funct3 == 3'd0) d_alu = ALU_ADDW;
        else if (funct3 == 3'd1 && funct7 == 7'b0) d_alu = ALU_SLLW;
        else if (funct3 == 3'd5 && funct7 == 7'b0) d_alu = ALU_SRLW;
        else if (funct3 == 3'd5 && funct7 == 7'b0100000) d_alu = ALU_SRAW;
        else d_ill = 1'b1;
      end
      OPC_OP: begin
        d_reg_wen = 1'b1;
        if (funct7 == 7'b0) d_alu = base_alu(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))
          d_alu = base_alu(funct3, 1'b1);
        else if (funct7 == 7'b0000001 && RVM_EN) d_alu = mul_alu(funct3);
        else d_ill = 1'b1;
      end
      OPC_OP32: begin
        d_reg_wen = 1'b1;
        if (!XLEN64) d_ill = 1'b1;
        else if (funct7 == 7'b0 && funct3 == 3'd0) d_alu = ALU_ADDW;
        else if (funct7 == 7'b0 && funct3 == 3'd1) d_alu = ALU_SLLW;
        else if (funct7 == 7'b0 && funct3 == 3'd5) d_alu = ALU_SRLW;
        else if (funct7 == 7'b0100000 && funct3 == 3'd0) d_alu = ALU_SUBW;
        else if (funct7 == 7'b0100000 && funct3 == 3'd5) d_alu = ALU_SRAW;
        else if (funct7 == 7'b0000001 && RVM_EN) begin
          case (funct3)
            3'd0:    d_alu = ALU_MULW;
            3'd4:    d_alu = ALU_DIVW;
            3'd5:    d_alu = ALU_DIVUW;
            3'd6:    d_alu = ALU_REMW;
            3'd7:    d_alu = ALU_REMUW;
            default: d_ill = 1'b1;
          endcase
        end
        else d_ill = 1'b1;
      end
      OPC_FENCE:  d_ill = (funct3 != 3'd0);
      OPC_SYSTEM: d_ill = !(in_inst == 32'h0000_0073 || in_inst == 32'h0010_0073);
      default:    d_ill = 1'b1;
    endcase
    // an illegal instruction must not cause any architectural side effect
    if (d_ill) begin
      d_alu = ALU_ADD; d_a_sel = A_RS1; d_b_sel = B_RS2;
      d_pc_sel = PC_SEQ; d_wreg_sel = WB_ALU;
      d_reg_wen = 1'b0; d_mem_wen = 1'b0; d_mem_ren = 1'b0;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_alu_sel   <= '0;
      out_alu_a_sel <= '0;
      out_alu_b_sel <= '0;
      out_pc_sel    <= '0;
      out_wreg_sel  <= '0;
      out_reg_wen   <= 1'b0;
      out_mem_wen   <= 1'b0;
      out_mem_ren   <= 1'b0;
      out_func3     <= '0;
      out_illegal   <= 1'b0;
      illegal_cnt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_imm       <= XLEN'($signed(d_imm32));
      out_rs1       <= in_inst[19:15];
      out_rs2       <= in_inst[24:20];
      out_rd        <= in_inst[11:7];
      out_alu_sel   <= d_alu;
      out_alu_a_sel <= d_a_sel;
      out_alu_b_sel <= d_b_sel;
      out_pc_sel    <= d_pc_sel;
      out_wreg_sel  <= d_wreg_sel;
      out_reg_wen   <= d_reg_wen;
      out_mem_wen   <= d_mem_wen;
      out_mem_ren   <= d_mem_ren;
      out_func3     <= funct3;
      out_illegal   <= d_ill;
      if (d_ill && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ysyx_22040759_decode_stage.md
YSYX_22040759_DECODE_STAGE -- requirements
Module: ysyx_22040759_decode_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width; SHALL accept only 32 or 64.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  synchronous, active-low reset.
REQ-004 Port in_valid  input  1  upstream holds a valid instruction.
REQ-005 Port in_ready  output  1  stage can accept this cycle.
REQ-006 Port in_inst  input  32  instruction word.
REQ-007 Port in_pc  input  XLEN  instruction address.
REQ-008 Port flush  input  1  kill the held and the incoming instruction.
REQ-009 Port out_valid  output  1  decoded bundle valid.
REQ-010 Port out_ready  input  1  downstream accepts the bundle.
REQ-011 Port out_pc / out_imm  output  XLEN each  registered PC; sign-extended immediate.
REQ-012 Port out_rs1 / out_rs2 / out_rd  output  5 each  register addresses.
REQ-013 Port out_alu_sel  output  5  ALU op (shared define header).
REQ-014 Port out_alu_a_sel / out_alu_b_sel / out_pc_sel / out_wreg_sel  output  2 each  mux selects.
REQ-015 Port out_reg_wen / out_mem_wen / out_mem_ren  output  1 each  write/memory enables.
REQ-016 Port out_func3  output  3  inst[14:12].
REQ-017 Port out_illegal  output  1  bundle holds an undecodable instruction.
REQ-018 Port illegal_cnt  output  16  saturating count of accepted illegal instructions.

Function
REQ-019 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-020 Accept SHALL occur when in_valid && in_ready && !flush; decoded bundle SHALL appear registered the next cycle (latency 1).
REQ-021 While out_valid && !out_ready all out_* SHALL hold stable.
REQ-022 out_valid SHALL clear after out_ready handshake with no new accept.
REQ-023 flush SHALL clear out_valid next cycle and SHALL win over a simultaneous accept (instruction dropped, not counted).
REQ-024 Immediates: U for LUI/AUIPC, J for JAL, I for JALR/LOAD/OP-IMM/OP-IMM-32, S for STORE, B for BRANCH, zero for OP/OP-32; sign bit inst[31] extended to XLEN.
REQ-025 Decoded set SHALL be the full RV64I base (RV32I when XLEN=32): loads/stores all widths, all branches, OP/OP-IMM, W-forms; branches SHALL drive pc_sel=branch-unit.
REQ-026 Illegal: unknown opcode/funct3/funct7, W-forms or shamt[5]=1 when XLEN=32, or M-ops without REQ-033; out_illegal=1 and reg_wen, mem_wen, mem_ren SHALL be 0.
REQ-027 illegal_cnt SHALL increment by 1 per accepted illegal instruction and saturate at 0xFFFF.
REQ-028 Every output field SHALL be a pure function of the accepted in_inst/in_pc; no simulation-only prints in synthesizable paths.

Reset
REQ-029 On clk edge with rst_n=0: out_valid=0, illegal_cnt=0, all out_* fields 0.
REQ-030 Reset mid-handshake SHALL discard the held bundle; in_ready SHALL be 1 the cycle after reset deasserts.
REQ-031 Reset SHALL dominate flush and accept.

Configuration
REQ-032 Macro YSYX_22040759_RVM_EN selects M-extension decode.
REQ-033 Defined: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (and W-forms when XLEN=64) decoded with reg_wen=1, wreg_sel=ALU, dedicated alu_sel codes.
REQ-034 Undefined: funct7=0000001 in OP/OP-32 SHALL be illegal per REQ-026.

Verification
REQ-035 XLEN=64, accept 0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFFFFFFFFFF, reg_wen=1, out_illegal=0.
REQ-036 out_valid=1, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, bundle unchanged; out_ready=1 -> new instruction registered next cycle.
REQ-037 flush=1 in accept cycle of 0xFFF10093 -> out_valid=0 next cycle, illegal_cnt unchanged.
REQ-038 Accept 0x00000000 -> out_illegal=1, all enables 0, illegal_cnt=1; 65536 illegal accepts -> illegal_cnt=0xFFFF.
REQ-039 Accept 0x022081B3 (mul x3,x1,x2) -> with macro: legal, rd=3, reg_wen=1; without: out_illegal=1, illegal_cnt+1.
REQ-040 XLEN=32, accept 0x0010809B (addiw) -> out_illegal=1; rst_n=0 with out_valid=1 -> out_valid=0, illegal_cnt=0 next cycle.
